// File: rtl/seg7x8_scan_decoder.sv
// Passive decoder for an 8-digit multiplexed 7-segment scan bus (AN/CAT).
// Optional scan timeout and STALL flag: define SEG7_SCAN_TIMEOUT_EN.
module seg7x8_scan_decoder #(
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic [7:0]  AN,
   input  logic [7:0]  CAT,
   output logic [31:0] HEX_OUT,
   output logic [7:0]  DP_OUT,
   output logic [7:0]  BLANK_OUT,
   output logic [7:0]  SEG_ERR,
   output logic        FRAME_DONE,
   output logic        AN_ERR,
   output logic        STALL
);

   typedef enum logic [1:0] {
      SYNC,
      COLLECT,
      PUBLISH
   } state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1) begin : g_bad_param
      $error("seg7x8_scan_decoder: SETTLE or TIMEOUT out of range");
   end

   state_t      state_q, state_d;
   logic [15:0] sample_q;
   logic [3:0]  cnt_q, cnt_d;
   logic        an_err_q;
   logic [7:0]  seen_q, seen_d;
   logic [31:0] hsh_q, hsh_d;
   logic [7:0]  dsh_q, dsh_d;
   logic [7:0]  bsh_q, bsh_d;
   logic [7:0]  esh_q, esh_d;
   logic [31:0] hex_q, hex_d;
   logic [7:0]  dp_q, dp_d;
   logic [7:0]  blank_q, blank_d;
   logic [7:0]  err_q, err_d;
   logic        done_q, done_d;

   logic [7:0]  an_sel;
   logic        an_none;
   logic        an_multi;
   logic [2:0]  idx;
   logic        same;
   logic        accept;
   logic        wr;

   // Acceptance fires on the tick the run length first equals SETTLE.
   always_comb begin
      an_sel   = ~AN;
      an_none  = (an_sel == 8'h00);
      an_multi = ((an_sel & (an_sel - 8'd1)) != 8'h00);
      idx      = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (an_sel[i]) idx = 3'(i);
      end
      same   = ({AN, CAT} == sample_q);
      cnt_d  = 4'd1;
      if (same) cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
      accept = CE && !an_none && !an_multi && (cnt_d == SETTLE_C) &&
               !(same && cnt_q == SETTLE_C);
   end

   logic [6:0] seg_s;
   logic [3:0] nib;
   logic       blank;
   logic       serr;
   logic       dp;

   always_comb begin
      seg_s = ~CAT[6:0];
      dp    = ~CAT[7];
      nib   = 4'h0;
      blank = 1'b0;
      serr  = 1'b0;
      case (seg_s)
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h6F: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         7'h00: blank = 1'b1;
         default: serr = 1'b1;
      endcase
   end

`ifdef SEG7_SCAN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_C = TW'(TIMEOUT);
   logic [TW-1:0] to_q, to_d;
   logic          stall_q, stall_d;
   logic          to_hit;
`endif

   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      hsh_d   = hsh_q;
      dsh_d   = dsh_q;
      bsh_d   = bsh_q;
      esh_d   = esh_q;
      hex_d   = hex_q;
      dp_d    = dp_q;
      blank_d = blank_q;
      err_d   = err_q;
      done_d  = 1'b0;
      wr      = 1'b0;
      unique case (state_q)
         SYNC: begin
            if (accept && idx == 3'd0) begin
               wr      = 1'b1;
               seen_d  = 8'h01;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (accept) begin
               wr     = 1'b1;
               seen_d = seen_q | (8'h01 << idx);
               if (seen_d == 8'hFF) state_d = PUBLISH;
            end
         end
         PUBLISH: begin
            hex_d   = hsh_q;
            dp_d    = dsh_q;
            blank_d = bsh_q;
            err_d   = esh_q;
            done_d  = 1'b1;
            seen_d  = 8'h00;
            state_d = COLLECT;
            if (accept) begin
               wr     = 1'b1;
               seen_d = 8'h01 << idx;
            end
         end
         default: state_d = SYNC;
      endcase
      if (wr) begin
         hsh_d[{idx, 2'b00} +: 4] = nib;
         dsh_d[idx] = dp;
         bsh_d[idx] = blank;
         esh_d[idx] = serr;
      end
`ifdef SEG7_SCAN_TIMEOUT_EN
      to_d    = to_q;
      stall_d = stall_q;
      to_hit  = 1'b0;
      if (accept) begin
         to_d    = '0;
         stall_d = 1'b0;
      end else if (CE && to_q != TO_C) begin
         to_d = to_q + 1'b1;
         if (to_d == TO_C) to_hit = 1'b1;
      end
      if (to_hit) begin
         stall_d = 1'b1;
         state_d = SYNC;
         seen_d  = 8'h00;
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= SYNC;
         sample_q <= '0;
         cnt_q    <= '0;
         an_err_q <= 1'b0;
         seen_q   <= '0;
         hsh_q    <= '0;
         dsh_q    <= '0;
         bsh_q    <= '0;
         esh_q    <= '0;
         hex_q    <= '0;
         dp_q     <= '0;
         blank_q  <= 8'hFF;
         err_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         if (CE) begin
            sample_q <= {AN, CAT};
            cnt_q    <= cnt_d;
            if (an_multi) an_err_q <= 1'b1;
         end
         state_q <= state_d;
         seen_q  <= seen_d;
         hsh_q   <= hsh_d;
         dsh_q   <= dsh_d;
         bsh_q   <= bsh_d;
         esh_q   <= esh_d;
         hex_q   <= hex_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

`ifdef SEG7_SCAN_TIMEOUT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         to_q    <= '0;
         stall_q <= 1'b0;
      end else begin
         to_q    <= to_d;
         stall_q <= stall_d;
      end
   end

   assign STALL = stall_q;
`else
   assign STALL = 1'b0;
`endif

   assign HEX_OUT    = hex_q;
   assign DP_OUT     = dp_q;
   assign BLANK_OUT  = blank_q;
   assign SEG_ERR    = err_q;
   assign FRAME_DONE = done_q;
   assign AN_ERR     = an_err_q;

endmodule

// File: tb/tb_seg7x8_scan_decoder.sv
// Bench for seg7x8_scan_decoder: directed scans plus randomized scans
// checked every clock against a frame-level reference model.
module tb_seg7x8_scan_decoder;

   localparam int SETTLE_P = 2;
   localparam int TO_P     = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CE  = 1'b0;
   logic [7:0]  AN  = 8'hFF;
   logic [7:0]  CAT = 8'hFF;
   logic [31:0] HEX_OUT;
   logic [7:0]  DP_OUT;
   logic [7:0]  BLANK_OUT;
   logic [7:0]  SEG_ERR;
   logic        FRAME_DONE;
   logic        AN_ERR;
   logic        STALL;

   seg7x8_scan_decoder #(
      .SETTLE  (SETTLE_P),
      .TIMEOUT (TO_P)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CE         (CE),
      .AN         (AN),
      .CAT        (CAT),
      .HEX_OUT    (HEX_OUT),
      .DP_OUT     (DP_OUT),
      .BLANK_OUT  (BLANK_OUT),
      .SEG_ERR    (SEG_ERR),
      .FRAME_DONE (FRAME_DONE),
      .AN_ERR     (AN_ERR),
      .STALL      (STALL)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int n_done = 0;

   bit [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                          7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                          7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] cat_of(input logic [3:0] n, input bit d);
      return ~{d, SEG[n]};
   endfunction

   // {err, blank, nibble}
   function automatic logic [5:0] dec(input logic [7:0] cat);
      logic [6:0] s;
      s = ~cat[6:0];
      if (s == 7'h00) return 6'b01_0000;
      for (int n = 0; n < 16; n++) begin
         if (SEG[n] == s) return {2'b00, 4'(n)};
      end
      return 6'b10_0000;
   endfunction

   // Reference model state
   logic [15:0] m_prev;
   int          m_run;
   bit          m_sync;
   bit          m_pend;
   bit   [7:0]  m_seen;
   logic [31:0] m_shn;
   logic [7:0]  m_shd, m_shb, m_she;
   logic [31:0] m_hex;
   logic [7:0]  m_dp, m_blank, m_err;
   bit          m_done, m_anerr, m_stall;
   int          m_since;

   task automatic m_reset();
      m_prev  = '0;
      m_run   = 0;
      m_sync  = 1;
      m_pend  = 0;
      m_seen  = '0;
      m_shn   = '0;
      m_shd   = '0;
      m_shb   = '0;
      m_she   = '0;
      m_hex   = '0;
      m_dp    = '0;
      m_blank = 8'hFF;
      m_err   = '0;
      m_done  = 0;
      m_anerr = 0;
      m_stall = 0;
      m_since = 0;
   endtask

   task automatic model_step();
      logic [5:0] r;
      int d, nsel;
      bit acc;
      m_done = 0;
      if (m_pend) begin
         m_hex   = m_shn;
         m_dp    = m_shd;
         m_blank = m_shb;
         m_err   = m_she;
         m_done  = 1;
         m_pend  = 0;
         m_seen  = '0;
      end
      if (CE) begin
         m_run  = ({AN, CAT} == m_prev) ? m_run + 1 : 1;
         m_prev = {AN, CAT};
         nsel   = $countones(~AN);
         if (nsel > 1) m_anerr = 1;
         acc = (nsel == 1) && (m_run == SETTLE_P);
         if (acc) begin
            d = 0;
            for (int i = 0; i < 8; i++) if (!AN[i]) d = i;
            if (!m_sync || d == 0) begin
               r = dec(CAT);
               m_shn[4*d +: 4] = r[3:0];
               m_shb[d] = r[4];
               m_she[d] = r[5];
               m_shd[d] = ~CAT[7];
               m_seen[d] = 1;
               m_sync = 0;
               if (m_seen == 8'hFF) m_pend = 1;
            end
            m_since = 0;
            m_stall = 0;
         end
`ifdef SEG7_SCAN_TIMEOUT_EN
         else if (m_since < TO_P) begin
            m_since++;
            if (m_since == TO_P) begin
               m_stall = 1;
               m_sync  = 1;
               m_seen  = '0;
            end
         end
`endif
      end
   endtask

   task automatic cmp_all();
      chk("done", FRAME_DONE, m_done);
      chk("hex", HEX_OUT, m_hex);
      chk("flags", {DP_OUT, BLANK_OUT, SEG_ERR}, {m_dp, m_blank, m_err});
      chk("anerr", AN_ERR, m_anerr);
      chk("stall", STALL, m_stall);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      cmp_all();
      if (FRAME_DONE) n_done++;
   endtask

   task automatic drv(input logic [7:0] an, input logic [7:0] cat,
                      input logic ce);
      AN  = an;
      CAT = cat;
      CE  = ce;
      tick();
   endtask

   task automatic show(input int i, input logic [7:0] cat, input int hold);
      logic [7:0] an;
      an = ~(8'h01 << i);
      repeat (hold) drv(an, cat, 1'b1);
   endtask

   task automatic frame(input logic [31:0] hx, input logic [7:0] dpm,
                        input int hold);
      for (int i = 0; i < 8; i++) show(i, cat_of(hx[4*i +: 4], dpm[i]), hold);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      m_reset();
      #1;
      cmp_all();
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   localparam logic [31:0] HX = 32'h9C32A792;
   localparam logic [7:0]  DPX = 8'h74;

   initial begin
      int base;
      int ord[8];
      m_reset();
      repeat (2) @(posedge CLK);
      #1;
      cmp_all();
      RST = 1'b0;

      // Full frame, scan order 0..7
      frame(HX, DPX, 4);
      chk("p1_hex", HEX_OUT, HX);
      chk("p1_dp", DP_OUT, DPX);
      chk("p1_blank", BLANK_OUT, 8'h00);
      chk("p1_err", SEG_ERR, 8'h00);
      chk("p1_ndone", n_done, 1);

      // Digits 1..7 blanked, digit 0 shows 2
      show(0, cat_of(4'h2, 1'b0), 4);
      for (int i = 1; i < 8; i++) show(i, 8'hFF, 4);
      chk("p2_hex", HEX_OUT, 32'h00000002);
      chk("p2_blank", BLANK_OUT, 8'hFE);
      chk("p2_ndone", n_done, 2);

      // Invalid pattern on digit 3
      for (int i = 0; i < 8; i++) begin
         if (i == 3) show(i, ~{DPX[3], 7'h12}, 4);
         else show(i, cat_of(HX[4*i +: 4], DPX[i]), 4);
      end
      chk("p3_err", SEG_ERR, 8'h08);
      chk("p3_hex", HEX_OUT, 32'h9C320792);
      chk("p3_ndone", n_done, 3);

      // One tick per digit never settles
      repeat (3) frame(HX, DPX, 1);
      chk("p4_ndone", n_done, 3);
      repeat (3) drv(8'hF5, 8'hFF, 1'b1);
      chk("p4_anerr", AN_ERR, 1'b1);
      frame(HX, DPX, 3);
      chk("p4_anerr_hold", AN_ERR, 1'b1);
      chk("p4_ndone2", n_done, 4);

      // Reset mid-frame; resync needs digit 0
      for (int i = 0; i < 5; i++) show(i, cat_of(4'h5, 1'b1), 3);
      do_reset();
      chk("p5_hex", HEX_OUT, 32'h0);
      chk("p5_blank", BLANK_OUT, 8'hFF);
      chk("p5_anerr", AN_ERR, 1'b0);
      base = n_done;
      for (int i = 3; i < 8; i++) show(i, cat_of(4'h1, 1'b0), 3);
      chk("p5_nosync", n_done, base);
      frame(HX, DPX, 3);
      chk("p5_ndone", n_done, base + 1);
      chk("p5_hex2", HEX_OUT, HX);

      // Randomized scans
      base = n_done;
      for (int f = 0; f < 60; f++) begin
         for (int i = 0; i < 8; i++) ord[i] = i;
         for (int i = 7; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
         end
         for (int k = 0; k < 8; k++) begin
            logic [7:0] cat, an;
            int hold, sel;
            sel = $urandom_range(15, 0);
            if (sel == 0) cat = {1'b1, 7'h7F};
            else if (sel == 1) cat = 8'($urandom);
            else cat = cat_of(4'($urandom), 1'($urandom));
            hold = $urandom_range(4, 1);
            an = ~(8'h01 << ord[k]);
            for (int h = 0; h < hold; h++)
               drv(an, cat, 1'($urandom_range(3, 0) != 0));
            if ($urandom_range(7, 0) == 0)
               repeat ($urandom_range(3, 1)) drv(8'hFF, 8'($urandom), 1'b1);
            if ($urandom_range(39, 0) == 0) begin
               int a, b;
               a = $urandom_range(7, 0);
               b = (a + 1 + $urandom_range(6, 0)) % 8;
               an = ~((8'h01 << a) | (8'h01 << b));
               drv(an, cat, 1'b1);
            end
         end
      end
      chk("rand_frames", n_done > base, 1'b1);

`ifdef SEG7_SCAN_TIMEOUT_EN
      frame(HX, DPX, 3);
      frame(HX, DPX, 3);
      chk("to_pre_hex", HEX_OUT, HX);
      repeat (20) drv(8'hFF, 8'hFF, 1'b1);
      chk("to_stall", STALL, 1'b1);
      chk("to_hold_hex", HEX_OUT, HX);
      base = n_done;
      show(0, cat_of(4'h3, 1'b0), 3);
      chk("to_clear", STALL, 1'b0);
      for (int i = 1; i < 8; i++) show(i, cat_of(4'h3, 1'b0), 3);
      chk("to_ndone", n_done, base + 1);
      chk("to_hex", HEX_OUT, 32'h33333333);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7x8_scan_decoder.md
Name: seg7x8_scan_decoder

Overview:
- Passive monitor on the multiplexed 8-digit 7-segment scan bus (AN/CAT).
- Samples the scan, decodes each digit's cathode pattern back to a hex nibble, a decimal-point flag and a blank flag, and publishes a coherent 32-bit word once per complete frame.
- Used for on-chip readback and self-check of the display driver path.

Parameters:
- SETTLE, 2, consecutive identical CE-qualified samples of {AN,CAT} required before a digit is accepted (range 1..15).
- TIMEOUT, 4096, CE ticks without an accepted digit before STALL asserts (used only with the optional feature).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- CE  in  1  sample enable; the block does nothing when CE=0
- AN  in  8  anode select, active-low, one-hot; AN[i]=0 selects digit i
- CAT  in  8  cathodes, active-low; CAT[0..6]=segments a..g, CAT[7]=DP
- HEX_OUT  out  32  decoded nibbles; digit i maps to HEX_OUT[4i+3:4i]
- DP_OUT  out  8  bit i=1 when DP of digit i is lit
- BLANK_OUT  out  8  bit i=1 when segments a..g of digit i are all off
- SEG_ERR  out  8  bit i=1 when digit i held an undecodable pattern in the last frame
- FRAME_DONE  out  1  one-cycle pulse when outputs update
- AN_ERR  out  1  sticky; AN had more than one low bit while CE=1; cleared only by RST
- STALL  out  1  scan timeout, optional feature only; otherwise tied to 0

Behaviour:
- Reset values:
  - HEX_OUT=0, DP_OUT=0, BLANK_OUT=FF, SEG_ERR=0, FRAME_DONE=0, AN_ERR=0, STALL=0.
  - State=SYNC, stability counter=0, seen mask=0, shadow registers=0.
- Sampling:
  - On CE=1, register {AN,CAT}.
  - If the sample equals the previous sample, increment the stability counter (saturating); otherwise reload it to 1.
  - A digit is accepted when the counter reaches SETTLE, exactly once per stable run.
- Decoding of s=~CAT[6:0] (gfedcba, active-high):
  - 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 decode to nibbles 0..F.
  - s=00 means blank: nibble=0, blank=1.
  - Any other value: nibble=0, blank=0, seg_err=1.
  - dp = ~CAT[7], independent of the segment decode.
- AN=FF (no digit selected): the sample is never accepted and does not disturb the seen mask.
- AN not one-hot (two or more bits low): the sample is never accepted; AN_ERR is set.
- States:
  - SYNC: wait for an accepted digit 0. On that, write the shadow for digit 0, set seen=01, and go to COLLECT.
  - COLLECT: each accepted digit i writes shadow[i] and sets seen[i]. When seen becomes FF, go to PUBLISH.
  - Re-acceptance of a digit already in seen overwrites its shadow entry; the newest value wins.
  - PUBLISH (one cycle, independent of CE): copy the shadows to the outputs, pulse FRAME_DONE, set seen=0, go to COLLECT.
  - Latency: FRAME_DONE is asserted in the clock after the cycle in which the eighth distinct digit is accepted.
  - An acceptance coinciding with PUBLISH belongs to the next frame and is applied after the copy.
- Outputs change only in PUBLISH (or reset). Between frames they hold.
- RST mid-frame: immediate return to the reset state; the partial frame is discarded.
- The scan order is arbitrary. A frame completes whenever all 8 digits have been seen.

Optional Feature:
- Macro SEG7_SCAN_TIMEOUT_EN.
- Defined:
  - A counter counts CE ticks since the last accepted digit.
  - On reaching TIMEOUT: STALL=1, state to SYNC, seen cleared. Published outputs hold.
  - STALL clears on the next accepted digit.
- Undefined:
  - No counter is built.
  - STALL is constant 0.
  - The TIMEOUT parameter is unused.

Test Plan:
1. Scan driver with CE=1, HEX=9C32A792, DP=74, no blanking, each digit held 4 CE ticks, scan order 0..7 -> after first full frame FRAME_DONE pulses once; HEX_OUT=9C32A792, DP_OUT=74, BLANK_OUT=00, SEG_ERR=00.
2. Same scan, but digits 1..7 blanked (CAT[6:0]=7F) and digit 0 showing 2 -> HEX_OUT=00000002, BLANK_OUT=FE.
3. Digit 3 driven with ~s=~12 (invalid pattern) -> SEG_ERR=08, HEX_OUT[15:12]=0, other nibbles correct.
4. SETTLE=2, each digit held 1 CE tick -> no acceptance, FRAME_DONE never pulses; AN=F5 for 3 ticks -> AN_ERR=1 and stays 1.
5. RST asserted after digits 0..4 are accepted -> outputs at reset values; the next FRAME_DONE occurs only after a full frame starting at digit 0.
6. With SEG7_SCAN_TIMEOUT_EN, TIMEOUT=16: stop the scan for 20 CE ticks -> STALL=1 at the 16th tick, outputs hold; resume the scan -> STALL=0 on the first accepted digit, FRAME_DONE after the next full frame.
